// File: rtl/imul_share_arbiter.sv
// rtl/imul_share_arbiter.sv - shares one val/rdy integer multiplier among NREQ requesters.
// Define IMUL_SHARE_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module imul_share_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_val,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [64*NREQ-1:0]   req_msg,
  output logic [NREQ-1:0]      resp_val,
  input  logic [NREQ-1:0]      resp_rdy,
  output logic [31:0]          resp_msg,
  output logic                 mul_req_val,
  input  logic                 mul_req_rdy,
  output logic [63:0]          mul_req_msg,
  input  logic                 mul_resp_val,
  output logic                 mul_resp_rdy,
  input  logic [31:0]          mul_resp_msg,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [63:0]    opnd_q, opnd_d;
  logic [31:0]    res_q, res_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           run_q, run_d;
  logic [IDW-1:0] start;
  logic           found;
  logic [IDW-1:0] win;

`ifdef IMUL_SHARE_ARBITER_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDW-1:0] rr_q, rr_d;
  assign start = rr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
  end
`endif

  // run_q keeps req_rdy low until the first clock edge after reset release
  assign run_d = 1'b1;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(start) + i) % NREQ;
      if (!found && req_val[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    opnd_d       = opnd_q;
    res_d        = res_q;
    grant_d      = grant_q;
`ifndef IMUL_SHARE_ARBITER_FIXED_PRIO_EN
    rr_d         = rr_q;
`endif
    req_rdy      = '0;
    resp_val     = '0;
    mul_req_val  = 1'b0;
    mul_resp_rdy = 1'b0;
    busy         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_q && found) begin
          req_rdy[win] = 1'b1;
          opnd_d       = req_msg[64*int'(win) +: 64];
          grant_d      = win;
`ifndef IMUL_SHARE_ARBITER_FIXED_PRIO_EN
          rr_d         = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
`endif
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy        = 1'b1;
        mul_req_val = 1'b1;
        if (mul_req_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        busy         = 1'b1;
        mul_resp_rdy = 1'b1;
        if (mul_resp_val) begin
          res_d   = mul_resp_msg;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        busy              = 1'b1;
        resp_val[grant_q] = 1'b1;
        if (resp_rdy[grant_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      opnd_q  <= '0;
      res_q   <= '0;
      grant_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      grant_q <= grant_d;
      run_q   <= run_d;
    end
  end

  assign mul_req_msg = opnd_q;
  assign resp_msg    = res_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_imul_share_arbiter.sv
// tb/tb_imul_share_arbiter.sv - directed and randomized self-checking bench for imul_share_arbiter.
module tb_imul_share_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_val, req_rdy, resp_val, resp_rdy;
  logic [64*N-1:0] req_msg;
  logic [31:0]     resp_msg, mul_resp_msg;
  logic            mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy, busy;
  logic [63:0]     mul_req_msg;
  logic [1:0]      grant_id;

  imul_share_arbiter #(.NREQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  bit          pend [N];
  logic [63:0] pmsg [N];
  int          nxt = 0;
  logic [31:0] last_prod = '0;
  bit          rand_arrivals = 0;
  int          rr_exp [5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_val[i]          = pend[i];
      req_msg[64*i +: 64] = pmsg[i];
    end
  endtask

  task automatic arrivals();
    if (rand_arrivals)
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          pmsg[i] = {$urandom, $urandom};
        end
    drive_reqs();
  endtask

  // Requesters hold val until accepted, so the winner is simply the first
  // pending requester at or after the rotating start point.
  function automatic int model_winner();
    int s;
`ifdef IMUL_SHARE_ARBITER_FIXED_PRIO_EN
    s = 0;
`else
    s = nxt;
`endif
    for (int k = 0; k < N; k++)
      if (pend[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  task automatic cyc();
    @(negedge clk);
    arrivals();
    #1;
  endtask

  task automatic run_txn(input int exp_w, input int issue_stall, input int wait_lat,
                         input int resp_stall, input logic [N-1:0] bad_rdy);
    int w, guard;
    logic [N-1:0] oh;
    logic [31:0] a, b, prod;
    logic [63:0] op;
    cyc();
    resp_rdy     = '0;
    mul_resp_val = 1'($urandom);
    mul_req_rdy  = 1'($urandom);
    w = model_winner();
    guard = 0;
    while (w < 0 && guard < 200) begin
      chk("idle_no_req_rdy", req_rdy, 0);
      chk("idle_busy_wait", busy, 0);
      cyc();
      w = model_winner();
      guard++;
    end
    if (w < 0) begin
      checks++;
      failures++;
      $error("FAIL idle_timeout observed=no_request expected=request");
      return;
    end
    oh = '0;
    oh[w] = 1'b1;
    chk("idle_busy", busy, 0);
    chk("idle_resp_msg_hold", resp_msg, last_prod);
    chk("req_rdy_onehot", req_rdy, oh);
    op   = pmsg[w];
    a    = op[63:32];
    b    = op[31:0];
    prod = a * b;
    pend[w] = 1'b0;
    nxt = (w + 1) % N;
    for (int s = 0; s <= issue_stall; s++) begin
      cyc();
      mul_resp_val = 1'($urandom);
      mul_resp_msg = $urandom;
      resp_rdy     = N'($urandom);
      mul_req_rdy  = (s == issue_stall);
      chk("issue_val", mul_req_val, 1);
      chk("issue_msg", mul_req_msg, op);
      chk("issue_req_rdy", req_rdy, 0);
      chk("issue_busy", busy, 1);
      chk("issue_grant", grant_id, w);
      chk("issue_resp_val", resp_val, 0);
      chk("issue_mul_resp_rdy", mul_resp_rdy, 0);
      if (s == 0 && exp_w >= 0) chk("grant_order", grant_id, exp_w);
    end
    for (int s = 0; s <= wait_lat; s++) begin
      cyc();
      mul_req_rdy  = 1'($urandom);
      resp_rdy     = N'($urandom);
      mul_resp_val = (s == wait_lat);
      mul_resp_msg = (s == wait_lat) ? prod : $urandom;
      chk("wait_resp_rdy", mul_resp_rdy, 1);
      chk("wait_req_val", mul_req_val, 0);
      chk("wait_resp_val", resp_val, 0);
      chk("wait_req_rdy", req_rdy, 0);
    end
    for (int s = 0; s <= resp_stall; s++) begin
      cyc();
      mul_resp_val = 1'($urandom);
      mul_resp_msg = $urandom;
      mul_req_rdy  = 1'($urandom);
      resp_rdy     = (s == resp_stall) ? (bad_rdy | oh) : (bad_rdy & ~oh);
      chk("resp_val", resp_val, oh);
      chk("resp_msg", resp_msg, prod);
      chk("resp_req_rdy", req_rdy, 0);
      chk("resp_mul_resp_rdy", mul_resp_rdy, 0);
      chk("resp_busy", busy, 1);
    end
    last_prod = prod;
  endtask

  initial begin
    reset = 1'b0;
    req_val = '0; req_msg = '0; resp_rdy = '0;
    mul_req_rdy = 1'b0; mul_resp_val = 1'b0; mul_resp_msg = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pmsg[i] = '0; end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_resp_val", resp_val, 0);
    chk("rst_mul_req_val", mul_req_val, 0);
    chk("rst_mul_resp_rdy", mul_resp_rdy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_mul_req_msg", mul_req_msg, 0);
    chk("rst_resp_msg", resp_msg, 0);
    reset = 1'b1;

    pend[1] = 1'b1; pmsg[1] = {32'd3, 32'd5};
    run_txn(1, 0, 0, 0, '0);
    pend[2] = 1'b1; pmsg[2] = {32'd9, 32'd7};
    run_txn(2, 5, 3, 7, '0);
    pend[3] = 1'b1; pmsg[3] = {32'd11, 32'd13};
    run_txn(3, 0, 2, 3, 4'b0111);
    pend[0] = 1'b1; pmsg[0] = {32'hFFFFFFFF, 32'hFFFFFFFF};
    run_txn(0, 1, 1, 1, '0);
    pend[1] = 1'b1; pmsg[1] = {32'h0, 32'h12345678};
    run_txn(1, 0, 4, 0, '0);

    pend[2] = 1'b1; pmsg[2] = {32'd6, 32'd7};
    cyc();
    chk("mid_req_rdy", req_rdy, 4'b0100);
    pend[2] = 1'b0;
    cyc();
    mul_req_rdy = 1'b1;
    chk("mid_issue", mul_req_val, 1);
    cyc();
    mul_req_rdy = 1'b0; mul_resp_val = 1'b0;
    chk("mid_wait", mul_resp_rdy, 1);
    for (int i = 0; i < N; i++) begin pend[i] = 1'b1; pmsg[i] = {32'(i + 1), 32'd2}; end
    drive_reqs();
    #1 reset = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_mul_resp_rdy", mul_resp_rdy, 0);
    chk("async_req_rdy", req_rdy, 0);
    chk("async_resp_val", resp_val, 0);
    chk("async_grant", grant_id, 0);
    chk("async_resp_msg", resp_msg, 0);
    chk("async_mul_req_msg", mul_req_msg, 0);
    @(negedge clk);
    reset = 1'b1;
    nxt = 0;
    last_prod = '0;
    #1;
    chk("release_req_rdy", req_rdy, 0);

`ifdef IMUL_SHARE_ARBITER_FIXED_PRIO_EN
    rr_exp = '{0, 0, 0, 0, 0};
`else
    rr_exp = '{0, 1, 2, 3, 0};
`endif
    for (int k = 0; k < 5; k++) begin
      run_txn(rr_exp[k], $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), '0);
      for (int i = 0; i < N; i++) pend[i] = 1'b1;
    end

    rand_arrivals = 1'b1;
    repeat (60)
      run_txn(-1, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), N'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
